// File: rtl/sdram_mport_arbit.sv
// Multi-port SDRAM request arbiter. Grants one user port at a time
// (round-robin), hands the latched address/burst length to the write or
// read engine, and interleaves auto-refresh with priority over new grants.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// INIT_WAIT  | waiting for SDRAM initialisation to complete
// IDLE       | arbitration point: refresh first, then round-robin ports
// AREF       | refresh engine enabled until aref_end_i or timeout
// WRITE      | write engine enabled for the granted port
// READ       | read engine enabled for the granted port
// DONE       | one-cycle completion pulse to the granted port
module sdram_mport_arbit #(
  parameter int NUM_PORTS = 4,
  parameter int ADDR_W    = 24,
  parameter int BLEN_W    = 10,
  parameter int TIMEOUT   = 1023,
  localparam int PTR_W    = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1,
  localparam int CNT_W    = $clog2(TIMEOUT + 1)
) (
  input  logic                        sys_clk,
  input  logic                        sys_rst_n,
  input  logic                        init_end_i,
  input  logic                        aref_req_i,
  input  logic                        aref_end_i,
  input  logic [NUM_PORTS-1:0]        port_req_i,
  input  logic [NUM_PORTS-1:0]        port_we_i,
  input  logic [NUM_PORTS*ADDR_W-1:0] port_addr_i,
  input  logic [NUM_PORTS*BLEN_W-1:0] port_blen_i,
  output logic [NUM_PORTS-1:0]        port_gnt_o,
  output logic [NUM_PORTS-1:0]        port_done_o,
  output logic                        aref_en_o,
  output logic                        wr_en_o,
  output logic                        rd_en_o,
  input  logic                        wr_end_i,
  input  logic                        rd_end_i,
  output logic [ADDR_W-1:0]           eng_addr_o,
  output logic [BLEN_W-1:0]           eng_blen_o,
  output logic [PTR_W-1:0]            cur_port_o,
  output logic                        err_o
);

  typedef enum logic [2:0] {
    ST_INIT_WAIT,
    ST_IDLE,
    ST_AREF,
    ST_WRITE,
    ST_READ,
    ST_DONE
  } state_t;

  // The engine state is aborted one cycle after the enable has been high
  // for TIMEOUT cycles; that extra cycle carries the err_o pulse.
  localparam logic [CNT_W-1:0] CNT_TO    = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_TO_M1 = CNT_W'(TIMEOUT - 1);

  state_t                state_q, state_d;
  logic [PTR_W-1:0]      ptr_q, ptr_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [NUM_PORTS-1:0]  gnt_q, gnt_d;
  logic [NUM_PORTS-1:0]  done_q, done_d;
  logic                  aref_en_q, aref_en_d;
  logic                  wr_en_q, wr_en_d;
  logic                  rd_en_q, rd_en_d;
  logic                  err_q, err_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [BLEN_W-1:0]     blen_q, blen_d;
  logic [PTR_W-1:0]      cur_q, cur_d;

  logic [ADDR_W-1:0]     addr_arr [NUM_PORTS];
  logic [BLEN_W-1:0]     blen_arr [NUM_PORTS];
  logic                  win_vld;
  logic [PTR_W-1:0]      win_idx;
  logic [PTR_W-1:0]      cand;
  logic                  end_hit;

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_unpack
    assign addr_arr[g] = port_addr_i[g*ADDR_W +: ADDR_W];
    assign blen_arr[g] = port_blen_i[g*BLEN_W +: BLEN_W];
  end

  // Round-robin search: first requesting port after the last granted one.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    cand    = '0;
    for (int i = 1; i <= NUM_PORTS; i++) begin
      cand = PTR_W'((int'(ptr_q) + i) % NUM_PORTS);
      if (!win_vld && port_req_i[cand]) begin
        win_vld = 1'b1;
        win_idx = cand;
      end
    end
  end

  // Next-state and next-output logic; every output is a registered copy.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    gnt_d     = gnt_q;
    done_d    = '0;
    aref_en_d = aref_en_q;
    wr_en_d   = wr_en_q;
    rd_en_d   = rd_en_q;
    err_d     = 1'b0;
    addr_d    = addr_q;
    blen_d    = blen_q;
    cur_d     = cur_q;
    end_hit   = (state_q == ST_WRITE) ? wr_end_i : rd_end_i;
    case (state_q)
      ST_INIT_WAIT: begin
        if (init_end_i) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        if (aref_req_i) begin
          state_d   = ST_AREF;
          aref_en_d = 1'b1;
          cnt_d     = '0;
        end else if (win_vld) begin
          cur_d          = win_idx;
          gnt_d          = '0;
          gnt_d[win_idx] = 1'b1;
          addr_d         = addr_arr[win_idx];
          blen_d         = blen_arr[win_idx];
          cnt_d          = '0;
          // A zero-length burst still gets a grant cycle, but no engine.
          if (port_we_i[win_idx]) begin
            state_d = ST_WRITE;
            wr_en_d = (blen_arr[win_idx] != '0);
          end else begin
            state_d = ST_READ;
            rd_en_d = (blen_arr[win_idx] != '0);
          end
        end
      end
      ST_AREF: begin
        if (cnt_q == CNT_TO) begin
          state_d = ST_IDLE;
        end else if (aref_end_i) begin
          state_d   = ST_IDLE;
          aref_en_d = 1'b0;
        end else if (cnt_q == CNT_TO_M1) begin
          aref_en_d = 1'b0;
          err_d     = 1'b1;
          cnt_d     = cnt_q + CNT_W'(1);
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_WRITE, ST_READ: begin
        if (blen_q == '0 || cnt_q == CNT_TO || end_hit) begin
          state_d        = ST_DONE;
          done_d[cur_q]  = 1'b1;
          gnt_d          = '0;
          wr_en_d        = 1'b0;
          rd_en_d        = 1'b0;
        end else if (cnt_q == CNT_TO_M1) begin
          wr_en_d = 1'b0;
          rd_en_d = 1'b0;
          err_d   = 1'b1;
          cnt_d   = cnt_q + CNT_W'(1);
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        ptr_d   = cur_q;
      end
      default: state_d = ST_INIT_WAIT;
    endcase
  end

  // State and output registers; reset leaves port 0 as the first winner.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q   <= ST_INIT_WAIT;
      ptr_q     <= PTR_W'(NUM_PORTS - 1);
      cnt_q     <= '0;
      gnt_q     <= '0;
      done_q    <= '0;
      aref_en_q <= 1'b0;
      wr_en_q   <= 1'b0;
      rd_en_q   <= 1'b0;
      err_q     <= 1'b0;
      addr_q    <= '0;
      blen_q    <= '0;
      cur_q     <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      gnt_q     <= gnt_d;
      done_q    <= done_d;
      aref_en_q <= aref_en_d;
      wr_en_q   <= wr_en_d;
      rd_en_q   <= rd_en_d;
      err_q     <= err_d;
      addr_q    <= addr_d;
      blen_q    <= blen_d;
      cur_q     <= cur_d;
    end
  end

  assign port_gnt_o  = gnt_q;
  assign port_done_o = done_q;
  assign aref_en_o   = aref_en_q;
  assign wr_en_o     = wr_en_q;
  assign rd_en_o     = rd_en_q;
  assign err_o       = err_q;
  assign eng_addr_o  = addr_q;
  assign eng_blen_o  = blen_q;
  assign cur_port_o  = cur_q;

endmodule

// File: doc/sdram_mport_arbit.md
SDRAM_MPORT_ARBIT -- requirements
Module: sdram_mport_arbit

Interface
REQ-001 Parameter NUM_PORTS, default 4, number of user request ports (2..8).
REQ-002 Parameter ADDR_W, default 24, user address width.
REQ-003 Parameter BLEN_W, default 10, burst-length width.
REQ-004 Parameter TIMEOUT, default 1023, max cycles in an engine state before abort.
REQ-005 sys_clk  in  1  single clock; all logic rising-edge.
REQ-006 sys_rst_n  in  1  asynchronous active-low reset.
REQ-007 init_end_i  in  1  SDRAM init complete (level).
REQ-008 aref_req_i  in  1  refresh request; aref_end_i  in  1  refresh done pulse.
REQ-009 port_req_i  in  NUM_PORTS  per-port request, held until granted.
REQ-010 port_we_i  in  NUM_PORTS  per-port direction: 1 write, 0 read.
REQ-011 port_addr_i  in  NUM_PORTS*ADDR_W  packed addresses, port k at bits [k*ADDR_W +: ADDR_W].
REQ-012 port_blen_i  in  NUM_PORTS*BLEN_W  packed burst lengths, same packing.
REQ-013 port_gnt_o  out  NUM_PORTS  one-hot grant, high for the whole transaction.
REQ-014 port_done_o  out  NUM_PORTS  one-cycle completion pulse to the granted port.
REQ-015 aref_en_o / wr_en_o / rd_en_o  out  1 each  engine enables, mutually exclusive.
REQ-016 wr_end_i / rd_end_i  in  1 each  write/read engine completion pulses.
REQ-017 eng_addr_o  out  ADDR_W; eng_blen_o  out  BLEN_W  latched transaction parameters.
REQ-018 cur_port_o  out  clog2(NUM_PORTS)  index of granted port; err_o  out  1  timeout pulse.

Function
REQ-019 FSM states: INIT_WAIT, IDLE, AREF, WRITE, READ, DONE; all outputs registered.
REQ-020 INIT_WAIT -> IDLE on first cycle init_end_i=1; later drops of init_end_i ignored.
REQ-021 IDLE priority: aref_req_i first -> AREF; else any port_req_i -> WRITE/READ per winner's port_we_i.
REQ-022 Round-robin: search starts at last-granted index +1, wraps modulo NUM_PORTS.
REQ-023 Latency: request sampled in IDLE at edge N; port_gnt_o, cur_port_o, eng_* and wr_en_o/rd_en_o valid from cycle N+1.
REQ-024 At grant, eng_addr_o/eng_blen_o/direction latched; port inputs ignored until return to IDLE.
REQ-025 AREF: aref_en_o=1 until aref_end_i sampled, then IDLE; round-robin pointer unchanged.
REQ-026 WRITE/READ: enable held until matching wr_end_i/rd_end_i sampled; then DONE.
REQ-027 DONE (1 cycle): port_done_o[cur] =1, enables and port_gnt_o =0; then IDLE; pointer := cur.
REQ-028 aref_req_i during WRITE/READ never preempts; serviced in first IDLE after DONE.
REQ-029 port_blen_i =0 at grant: no engine enable; go straight to DONE; pointer advances normally.
REQ-030 Timeout counter clears on entering AREF/WRITE/READ; at TIMEOUT cycles without end pulse: err_o pulses 1 cycle, enables drop, go DONE (WRITE/READ) or IDLE (AREF).
REQ-031 End pulses not matching the current state ignored; port_req_i dropped before grant has no effect.
REQ-032 IDLE lasts at least 1 cycle between transactions (no back-to-back grant without IDLE).

Reset
REQ-033 sys_rst_n=0 at any time, including mid-burst: state INIT_WAIT, every output 0, eng_* 0, timeout counter 0, pointer NUM_PORTS-1 (port 0 wins first).

Verification
REQ-034 Reset, init_end_i=1, port_req_i=4'b1111, all reads, end pulse 3 cycles after each enable -> grant order 0,1,2,3,0; one done pulse each.
REQ-035 aref_req_i and port_req_i[2] (write, addr 0x00ABCD, blen 8) same IDLE cycle -> aref_en_o first; after aref_end_i, IDLE, then wr_en_o, eng_addr_o=0x00ABCD, eng_blen_o=8, port_gnt_o=4'b0100.
REQ-036 aref_req_i raised mid-write on port 1 -> wr_en_o held until wr_end_i; DONE, IDLE, then aref_en_o.
REQ-037 Port 3 read, blen 0 -> rd_en_o never asserted; port_done_o[3] two cycles after request sampled.
REQ-038 Port 0 write, no wr_end_i -> after TIMEOUT cycles err_o=1 one cycle, wr_en_o=0, port_done_o[0]=1 next cycle.
REQ-039 sys_rst_n low during READ -> all outputs 0 immediately; with init_end_i held 1, back to IDLE on first clock after release; port 0 granted first.
